// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM states, frame width and the
// oversample clock divider calculation.
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  // Rounded integer divide so the tick rate lands as close to BAUD*OVS as possible.
  function automatic int calc_div(input int clk_hz, input int baud, input int ovs);
    int d;
    d = baud * ovs;
    return (clk_hz + d / 2) / d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Synchronous FIFO with a registered head word, occupancy level and full/empty flags.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [DATA_W-1:0]        i_data,
  input  logic                     i_pop,
  output logic [DATA_W-1:0]        o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr;
  logic [AW-1:0]     r_rd;
  logic [LW-1:0]     r_level;
  logic [DATA_W-1:0] r_head;
  logic [AW-1:0]     w_rd_nxt;
  logic [LW-1:0]     w_after_pop;
  logic              w_wr;
  logic              w_rd;

  assign o_empty     = (r_level == '0);
  assign o_full      = (r_level == LW'(DEPTH));
  assign w_rd        = i_pop && !o_empty;
  assign w_wr        = i_push && (!o_full || w_rd);
  assign w_rd_nxt    = r_rd + AW'(1);
  assign w_after_pop = r_level - LW'(w_rd);
  assign o_data      = r_head;
  assign o_level     = r_level;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wr <= r_wr + AW'(1);
      if (w_rd) r_rd <= w_rd_nxt;
      r_level <= w_after_pop + LW'(w_wr);
    end
  end

  // Head tracks the word that will be at the read pointer after this cycle's ops.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_wr && (w_after_pop == '0)) begin
      r_head <= i_data;
    end else if (w_rd && (w_after_pop != '0)) begin
      r_head <= r_mem[w_rd_nxt];
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling feeding a receive FIFO stream.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 20000000,
  parameter int BAUD       = 115200,
  parameter int OVS        = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          HCLK,
  input  logic                          hwRst,
  input  logic                          rxd,
  output logic [DATA_BITS-1:0]          m_data,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic                          frame_err,
  output logic                          overflow,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int DIV = calc_div(CLK_HZ, BAUD, OVS);
  localparam int DW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OW  = $clog2(OVS);
  localparam int BW  = $clog2(DATA_BITS);

  rx_state_e            r_state;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rxd_d;
  logic [DW-1:0]        r_div;
  logic [OW-1:0]        r_ovs;
  logic [BW-1:0]        r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_ferr;
  logic                 r_perr;
  logic                 r_ovf;
  logic                 w_rxd_s;
  logic                 w_fall;
  logic                 w_tick;
  logic                 w_mid;
  logic                 w_end;
  logic                 w_par_bad;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_full;
  logic                 w_empty;

  assign w_rxd_s = r_sync2;
  assign w_fall  = r_rxd_d && !w_rxd_s;
  assign w_tick  = (r_state != IDLE) && (r_div == DW'(DIV - 1));
  assign w_mid   = (r_ovs == OW'(OVS / 2 - 1));
  assign w_end   = (r_ovs == OW'(OVS - 1));

  always_ff @(posedge HCLK) begin
    if (hwRst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxd_d <= 1'b1;
    end else begin
      r_sync1 <= rxd;
      r_sync2 <= r_sync1;
      r_rxd_d <= r_sync2;
    end
  end

  // Divider sits at zero in IDLE so every frame starts with a fresh phase.
  always_ff @(posedge HCLK) begin
    if (hwRst || r_state == IDLE || w_tick) r_div <= '0;
    else                                    r_div <= r_div + DW'(1);
  end

`ifdef UART_RX_PARITY_EN
  logic r_par;
  assign w_par_bad  = ^{r_shift, r_par};
  assign parity_err = r_perr;
`else
  assign w_par_bad  = 1'b0;
`endif

  always_ff @(posedge HCLK) begin
    if (r_state == DATA && w_tick && w_end) r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
`ifdef UART_RX_PARITY_EN
    if (r_state == PARITY && w_tick && w_end) r_par <= w_rxd_s;
`endif
  end

  always_ff @(posedge HCLK) begin
    if (hwRst) begin
      r_state <= IDLE;
      r_ovs   <= '0;
      r_bit   <= '0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
    end else begin
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      case (r_state)
        IDLE: if (w_fall) begin
          r_state <= START;
          r_ovs   <= '0;
        end
        START: if (w_tick) begin
          if (w_mid) begin
            r_ovs   <= '0;
            r_bit   <= '0;
            r_state <= w_rxd_s ? IDLE : DATA;
          end else r_ovs <= r_ovs + OW'(1);
        end
        DATA: if (w_tick) begin
          if (w_end) begin
            r_ovs <= '0;
            r_bit <= r_bit + BW'(1);
            if (r_bit == BW'(DATA_BITS - 1))
`ifdef UART_RX_PARITY_EN
              r_state <= PARITY;
`else
              r_state <= STOP;
`endif
          end else r_ovs <= r_ovs + OW'(1);
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (w_tick) begin
          if (w_end) begin
            r_ovs   <= '0;
            r_state <= STOP;
          end else r_ovs <= r_ovs + OW'(1);
        end
`endif
        STOP: if (w_tick) begin
          if (w_end) begin
            r_ovs   <= '0;
            r_state <= IDLE;
            if (!w_rxd_s)      r_ferr <= 1'b1;
            else if (w_par_bad) r_perr <= 1'b1;
          end else r_ovs <= r_ovs + OW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_push = (r_state == STOP) && w_tick && w_end && w_rxd_s && !w_par_bad;
  assign w_pop  = m_valid && m_ready;

  always_ff @(posedge HCLK) begin
    if (hwRst) r_ovf <= 1'b0;
    else       r_ovf <= w_push && w_full && !w_pop;
  end

  sync_fifo #(
    .DATA_W (DATA_BITS),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst     (hwRst),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (w_pop),
    .o_data  (m_data),
    .o_level (fifo_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_valid   = !w_empty;
  assign frame_err = r_ferr;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: drives serial frames at 176 cycles per bit and
// checks the FIFO stream, error pulses and reset behaviour.
module tb_uart_rx_fifo;

  localparam int BIT = 176;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  // Cycle whose closing edge samples the stop bit, relative to the start-bit drive.
  localparam int RDY_AT = 91 + BIT * (NB - 1) - 1;

  logic       HCLK = 1'b0;
  logic       hwRst = 1'b1;
  logic       rxd = 1'b1;
  logic       m_ready = 1'b0;
  logic [7:0] m_data;
  logic       m_valid;
  logic       frame_err;
  logic       overflow;
  logic [4:0] fifo_level;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  int total = 0;
  int bad = 0;
  int n_vcyc = 0, n_ferr = 0, n_ovf = 0, n_perr = 0, n_pop = 0;
  logic [7:0] rx_mem [0:255];
  bit par_bad = 1'b0;

  uart_rx_fifo dut (
    .HCLK       (HCLK),
    .hwRst      (hwRst),
    .rxd        (rxd),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .frame_err  (frame_err),
    .overflow   (overflow),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .fifo_level (fifo_level)
  );

  always #5 HCLK = ~HCLK;

  always @(negedge HCLK) begin
    if (m_valid) n_vcyc++;
    if (frame_err) n_ferr++;
    if (overflow) n_ovf++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) n_perr++;
`endif
    if (m_valid && m_ready) begin
      rx_mem[n_pop[7:0]] = m_data;
      n_pop++;
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop, input int rdy_at, input int rst_at);
    logic [10:0] bits;
`ifdef UART_RX_PARITY_EN
    bits = {stop, (^b) ^ par_bad, b, 1'b0};
`else
    bits = {1'b0, stop, b, 1'b0};
`endif
    for (int c = 0; c < NB * BIT; c++) begin
      if (c % BIT == 0) rxd = bits[c / BIT];
      if (rdy_at >= 0) m_ready = (c == rdy_at);
      if (rst_at >= 0 && c == rst_at) hwRst = 1'b1;
      @(posedge HCLK); #1;
      if (rst_at >= 0 && c == rst_at + 2) begin
        hwRst = 1'b0;
        break;
      end
    end
    rxd = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  task automatic drain(input int n);
    m_ready = 1'b1;
    idle(n);
    m_ready = 1'b0;
  endtask

  task automatic test_reset;
    hwRst = 1'b1;
    idle(3);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %0b expected 0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %0h expected 00", m_data); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL reset_level: got %0d expected 0", fifo_level); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %0b expected 0", frame_err); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf: got %0b expected 0", overflow); end
    hwRst = 1'b0;
    idle(2);
  endtask

  task automatic test_single;
    int p0, v0;
    p0 = n_pop; v0 = n_vcyc;
    m_ready = 1'b1;
    send_frame(8'hA5, 1'b1, -1, -1);
    idle(5);
    m_ready = 1'b0;
    total++; if (n_pop - p0 != 1) begin bad++; $display("FAIL single_count: got %0d expected 1", n_pop - p0); end
    total++; if (rx_mem[p0[7:0]] !== 8'hA5) begin bad++; $display("FAIL single_data: got %0h expected a5", rx_mem[p0[7:0]]); end
    total++; if (n_vcyc - v0 != 1) begin bad++; $display("FAIL single_valid_width: got %0d expected 1", n_vcyc - v0); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL single_level: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_back_to_back;
    int p0;
    logic [7:0] exp [3];
    exp[0] = 8'h00; exp[1] = 8'hFF; exp[2] = 8'h3C;
    p0 = n_pop;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1, -1, -1);
    idle(3);
    total++; if (fifo_level !== 5'd3) begin bad++; $display("FAIL b2b_level: got %0d expected 3", fifo_level); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL b2b_head: got %0h expected 00", m_data); end
    drain(10);
    total++; if (n_pop - p0 != 3) begin bad++; $display("FAIL b2b_count: got %0d expected 3", n_pop - p0); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (rx_mem[8'(p0 + i)] !== exp[i]) begin
        bad++; $display("FAIL b2b_order[%0d]: got %0h expected %0h", i, rx_mem[8'(p0 + i)], exp[i]);
      end
    end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL b2b_drained: got %0d expected 0", fifo_level); end
  endtask

  task automatic test_glitch;
    int f0;
    f0 = n_ferr;
    rxd = 1'b0;
    idle(40);
    rxd = 1'b1;
    idle(400);
    total++; if (n_ferr != f0) begin bad++; $display("FAIL glitch_ferr: got %0d expected 0", n_ferr - f0); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL glitch_level: got %0d expected 0", fifo_level); end
    send_frame(8'h81, 1'b1, -1, -1);
    idle(3);
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL glitch_after_level: got %0d expected 1", fifo_level); end
    total++; if (m_data !== 8'h81) begin bad++; $display("FAIL glitch_after_data: got %0h expected 81", m_data); end
    drain(3);
  endtask

  task automatic test_framing;
    int f0;
    f0 = n_ferr;
    send_frame(8'h55, 1'b0, -1, -1);
    idle(5);
    total++; if (n_ferr - f0 != 1) begin bad++; $display("FAIL frame_err_pulse: got %0d expected 1", n_ferr - f0); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL frame_level: got %0d expected 0", fifo_level); end
    idle(200);
  endtask

  task automatic test_overflow;
    int o0;
    o0 = n_ovf;
    m_ready = 1'b0;
    for (int i = 1; i <= 16; i++) send_frame(8'(i), 1'b1, -1, -1);
    total++; if (n_ovf != o0) begin bad++; $display("FAIL ovf_early: got %0d expected 0", n_ovf - o0); end
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_full_level: got %0d expected 16", fifo_level); end
    send_frame(8'h11, 1'b1, -1, -1);
    idle(3);
    total++; if (n_ovf - o0 != 1) begin bad++; $display("FAIL ovf_pulse: got %0d expected 1", n_ovf - o0); end
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL ovf_level: got %0d expected 16", fifo_level); end
    total++; if (m_data !== 8'h01) begin bad++; $display("FAIL ovf_head: got %0h expected 01", m_data); end
  endtask

  task automatic test_full_pop;
    int o0, p0;
    o0 = n_ovf; p0 = n_pop;
    send_frame(8'h11, 1'b1, RDY_AT, -1);
    idle(3);
    total++; if (n_ovf != o0) begin bad++; $display("FAIL fullpop_ovf: got %0d expected 0", n_ovf - o0); end
    total++; if (fifo_level !== 5'd16) begin bad++; $display("FAIL fullpop_level: got %0d expected 16", fifo_level); end
    total++; if (rx_mem[p0[7:0]] !== 8'h01) begin bad++; $display("FAIL fullpop_popped: got %0h expected 01", rx_mem[p0[7:0]]); end
    p0 = n_pop;
    drain(20);
    total++; if (n_pop - p0 != 16) begin bad++; $display("FAIL fullpop_count: got %0d expected 16", n_pop - p0); end
    for (int i = 0; i < 16; i++) begin
      total++;
      if (rx_mem[8'(p0 + i)] !== 8'(i + 2)) begin
        bad++; $display("FAIL fullpop_order[%0d]: got %0h expected %0h", i, rx_mem[8'(p0 + i)], 8'(i + 2));
      end
    end
  endtask

  task automatic test_reset_midframe;
    int p0;
    m_ready = 1'b0;
    send_frame(8'h33, 1'b1, -1, -1);
    idle(3);
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL midrst_pre_level: got %0d expected 1", fifo_level); end
    send_frame(8'h96, 1'b1, -1, 4 * BIT + 88);
    total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid: got %0b expected 0", m_valid); end
    total++; if (m_data !== 8'h00) begin bad++; $display("FAIL midrst_data: got %0h expected 00", m_data); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL midrst_level: got %0d expected 0", fifo_level); end
    idle(20);
    p0 = n_pop;
    send_frame(8'h5A, 1'b1, -1, -1);
    idle(3);
    total++; if (fifo_level !== 5'd1) begin bad++; $display("FAIL midrst_next_level: got %0d expected 1", fifo_level); end
    drain(3);
    total++; if (rx_mem[p0[7:0]] !== 8'h5A) begin bad++; $display("FAIL midrst_next_data: got %0h expected 5a", rx_mem[p0[7:0]]); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    int e0, f0;
    e0 = n_perr; f0 = n_ferr;
    par_bad = 1'b1;
    send_frame(8'h07, 1'b1, -1, -1);
    par_bad = 1'b0;
    idle(5);
    total++; if (n_perr - e0 != 1) begin bad++; $display("FAIL parity_pulse: got %0d expected 1", n_perr - e0); end
    total++; if (n_ferr != f0) begin bad++; $display("FAIL parity_ferr: got %0d expected 0", n_ferr - f0); end
    total++; if (fifo_level !== 5'd0) begin bad++; $display("FAIL parity_level: got %0d expected 0", fifo_level); end
  endtask
`endif

  initial begin
    test_reset;
    test_single;
    test_back_to_back;
    test_glitch;
    test_framing;
    test_overflow;
    test_full_pop;
    test_reset_midframe;
`ifdef UART_RX_PARITY_EN
    test_parity;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
